// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared definitions for the instruction fetch stage: the NOP
//            encoding used to pad invalid blocks, the fetch FSM state
//            encoding and a helper returning the byte size of a fetch block.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    // Number of bytes covered by one fetch block of core_width instructions.
    function automatic logic [31:0] blk_bytes(input int core_width);
        return 32'(core_width * 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Purpose  : Instruction-memory request/response bundle between the fetch
//            stage (master) and the instruction memory (slave).
// Ports    : imem_req_valid/imem_req_addr  master -> slave request
//            imem_req_ready                slave  -> master request accept
//            imem_resp_valid/imem_resp_data slave -> master in-order response
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_if #(
    parameter int CORE_WIDTH = 2
);
    localparam int INSTR_BLK_SIZE = CORE_WIDTH * 32;

    logic                      imem_req_valid;
    logic [31:0]               imem_req_addr;
    logic                      imem_req_ready;
    logic                      imem_resp_valid;
    logic [INSTR_BLK_SIZE-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid
// Purpose  : One-entry holding slot for a fetched block that arrived while
//            the downstream output register was held.
// Ports    : clk, reset_n        clock / asynchronous active-low reset
//            load, load_pc/blk   capture a block
//            unload, clear       empty the entry (moved out / flushed)
//            valid, pc, blk      current entry contents
// Revision : 1.0 - initial release
// ============================================================================
module fetch_skid #(
    parameter int BLK_W = 64
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             load,
    input  wire logic             unload,
    input  wire logic             clear,
    input  wire logic [31:0]      load_pc,
    input  wire logic [BLK_W-1:0] load_blk,
    output      logic             valid,
    output      logic [31:0]      pc,
    output      logic [BLK_W-1:0] blk
);
    logic             r_valid;
    logic [31:0]      r_pc;
    logic [BLK_W-1:0] r_blk;

    // Emptying wins over loading; the controller never asks for both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_blk   <= '0;
        end else if (clear || unload) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_pc    <= load_pc;
            r_blk   <= load_blk;
        end
    end

    assign valid = r_valid;
    assign pc    = r_pc;
    assign blk   = r_blk;
endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage. Issues one block request at a time,
//            presents returned blocks to decode through an output register
//            with a one-entry skid, and handles redirects by flushing and
//            draining any in-flight response.
// Ports    : clk, reset_n             clock / asynchronous active-low reset
//            imem                     instruction-memory bus (master side)
//            redirect_valid/_pc       flush and restart fetch at redirect_pc
//            hold_fd                  decode is not consuming the output
//            pc_addr_f/instr_blk_f    presented block address / contents
//            valid_f                  presented block is real
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          CORE_WIDTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    fetch_if.master                         imem,
    input  wire logic                       redirect_valid,
    input  wire logic [31:0]                redirect_pc,
    input  wire logic                       hold_fd,
    output      logic [31:0]                pc_addr_f,
    output      logic [CORE_WIDTH*32-1:0]   instr_blk_f,
    output      logic                       valid_f
);
    localparam int                        INSTR_BLK_SIZE = CORE_WIDTH * 32;
    localparam logic [31:0]               BLK_BYTES      = blk_bytes(CORE_WIDTH);
    localparam logic [INSTR_BLK_SIZE-1:0] NOP_BLK        = {CORE_WIDTH{C_NOP}};

    fetch_state_t              r_state;
    fetch_state_t              w_state_nxt;
    logic [31:0]               r_pc;
    logic [31:0]               w_pc_nxt;
    logic                      r_out_valid;
    logic [31:0]               r_out_pc;
    logic [INSTR_BLK_SIZE-1:0] r_out_blk;

    logic w_handshake;
    logic w_slot_free;
    logic w_out_load_resp;
    logic w_out_load_skid;
    logic w_out_clear;
    logic w_skid_load;
    logic w_skid_unload;
    logic w_skid_clear;

    logic                      w_skid_valid;
    logic [31:0]               w_skid_pc;
    logic [INSTR_BLK_SIZE-1:0] w_skid_blk;

    assign imem.imem_req_valid = (r_state == S_REQ);
    assign imem.imem_req_addr  = r_pc;
    assign w_handshake         = (r_state == S_REQ) && imem.imem_req_ready;
    assign w_slot_free         = !r_out_valid || !hold_fd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_out_load_resp = 1'b0;
        w_out_load_skid = 1'b0;
        w_out_clear     = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_unload   = 1'b0;
        w_skid_clear    = 1'b0;

        if (redirect_valid) begin
            // Flush everything; any response arriving now is dropped. Drain
            // only if a request is still in flight after this edge.
            w_pc_nxt     = redirect_pc;
            w_out_clear  = 1'b1;
            w_skid_clear = 1'b1;
            case (r_state)
                S_REQ:           w_state_nxt = w_handshake ? S_DRAIN : S_REQ;
                S_WAIT, S_DRAIN: w_state_nxt = imem.imem_resp_valid ? S_REQ : S_DRAIN;
                default:         w_state_nxt = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_handshake) begin
                        w_pc_nxt    = r_pc + BLK_BYTES;
                        w_state_nxt = S_WAIT;
                    end
                    w_out_clear = w_slot_free;
                end
                S_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        if (w_slot_free) begin
                            w_out_load_resp = 1'b1;
                            w_state_nxt     = S_REQ;
                        end else begin
                            w_skid_load = 1'b1;
                            w_state_nxt = S_STALL;
                        end
                    end else begin
                        w_out_clear = w_slot_free;
                    end
                end
                S_STALL: begin
                    if (!hold_fd) begin
                        w_out_load_skid = 1'b1;
                        w_skid_unload   = 1'b1;
                        w_state_nxt     = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem.imem_resp_valid) begin
                        w_state_nxt = S_REQ;
                    end
                    w_out_clear = w_slot_free;
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // pc already advanced at the handshake, so the block in flight starts
    // one block below it (modulo 2^32).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_blk   <= NOP_BLK;
        end else if (w_out_load_resp) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_pc - BLK_BYTES;
            r_out_blk   <= imem.imem_resp_data;
        end else if (w_out_load_skid) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= w_skid_pc;
            r_out_blk   <= w_skid_blk;
        end else if (w_out_clear) begin
            r_out_valid <= 1'b0;
        end
    end

    fetch_skid #(
        .BLK_W (INSTR_BLK_SIZE)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_skid_load),
        .unload   (w_skid_unload),
        .clear    (w_skid_clear),
        .load_pc  (r_pc - BLK_BYTES),
        .load_blk (imem.imem_resp_data),
        .valid    (w_skid_valid),
        .pc       (w_skid_pc),
        .blk      (w_skid_blk)
    );

    assign valid_f     = r_out_valid;
    assign pc_addr_f   = r_out_pc;
    assign instr_blk_f = r_out_valid ? r_out_blk : NOP_BLK;

    // The skid occupancy flag is implied by the S_STALL state.
    logic w_unused;
    assign w_unused = w_skid_valid;
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage with a one-outstanding
//            instruction memory model of configurable latency.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    localparam logic [63:0] NOP_BLK = {32'h0000_0013, 32'h0000_0013};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        hold_fd = 1'b0;
    logic [31:0] pc_addr_f;
    logic [63:0] instr_blk_f;
    logic        valid_f;

    int errors = 0;
    int checks = 0;

    fetch_if #(.CORE_WIDTH(2)) bus ();

    fetch_stage #(.CORE_WIDTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset_n        (rst_n),
        .imem           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hold_fd        (hold_fd),
        .pc_addr_f      (pc_addr_f),
        .instr_blk_f    (instr_blk_f),
        .valid_f        (valid_f)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] blk_of(input logic [31:0] a);
        return {32'hD000_0000 ^ (a + 32'd4), 32'hD000_0000 ^ a};
    endfunction

    // Memory model: accepts a request, answers mem_lat cycles later.
    int          mem_lat = 1;
    int          mem_cnt;
    logic        mem_pend;
    logic [31:0] mem_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_pend <= 1'b0;
            mem_addr <= '0;
            mem_cnt  <= 0;
        end else begin
            if (bus.imem_resp_valid) mem_pend <= 1'b0;
            else if (mem_pend && mem_cnt != 0) mem_cnt <= mem_cnt - 1;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mem_pend <= 1'b1;
                mem_addr <= bus.imem_req_addr;
                mem_cnt  <= mem_lat - 1;
            end
        end
    end

    assign bus.imem_resp_valid = mem_pend && (mem_cnt == 0);
    assign bus.imem_resp_data  = blk_of(mem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic rv, input logic [31:0] ra,
                              input logic vf, input logic [31:0] pcf);
        chk({tag, " req_valid"}, 64'(bus.imem_req_valid), 64'(rv));
        if (rv) chk({tag, " req_addr"}, 64'(bus.imem_req_addr), 64'(ra));
        chk({tag, " valid_f"}, 64'(valid_f), 64'(vf));
        if (vf) chk({tag, " pc_addr_f"}, 64'(pc_addr_f), 64'(pcf));
        chk({tag, " instr_blk_f"}, instr_blk_f, vf ? blk_of(pcf) : NOP_BLK);
    endtask

    typedef struct {
        logic        hold;   // hold_fd applied for the following edge
        logic        rv;     // expected imem_req_valid
        logic [31:0] ra;     // expected imem_req_addr
        logic        vf;     // expected valid_f
        logic [31:0] pcf;    // expected pc_addr_f
    } vec_t;

    vec_t vecs[10];

    initial begin
        bus.imem_req_ready = 1'b1;

        // Streaming fetch, then a 3-cycle hold that pushes 0x10 into the skid.
        vecs[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[2] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        vecs[6] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        vecs[7] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
        vecs[8] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        vecs[9] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset valid_f", 64'(valid_f), 64'd0);
        chk("reset pc_addr_f", 64'(pc_addr_f), 64'd0);
        chk("reset instr_blk_f", instr_blk_f, NOP_BLK);
        chk("reset req_valid", 64'(bus.imem_req_valid), 64'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            expect_out($sformatf("vec%0d", i), vecs[i].rv, vecs[i].ra, vecs[i].vf, vecs[i].pcf);
            hold_fd = vecs[i].hold;
            @(negedge clk);
        end

        // Redirect while waiting; stale 0x20 response arrives during drain.
        expect_out("pre_redir", 1'b1, 32'h20, 1'b1, 32'h18);
        mem_lat = 3;
        @(negedge clk);
        expect_out("wait20", 1'b0, 32'h0, 1'b0, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        expect_out("drain1", 1'b0, 32'h0, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        @(negedge clk);
        expect_out("drain2", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        expect_out("req100", 1'b1, 32'h100, 1'b0, 32'h0);
        mem_lat = 1;
        @(negedge clk);
        expect_out("wait100", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        expect_out("out100", 1'b1, 32'h108, 1'b1, 32'h100);

        // Redirect to 0x40 with ready low, then redirect during 0x40 handshake.
        bus.imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        expect_out("req40", 1'b1, 32'h40, 1'b0, 32'h0);
        bus.imem_req_ready = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        expect_out("drain40", 1'b0, 32'h0, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        @(negedge clk);
        expect_out("req200", 1'b1, 32'h200, 1'b0, 32'h0);
        @(negedge clk);
        expect_out("wait200", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        expect_out("out200", 1'b1, 32'h208, 1'b1, 32'h200);

        // Fill out and skid under hold, then redirect flushes both.
        hold_fd = 1'b1;
        @(negedge clk);
        expect_out("hold_a", 1'b0, 32'h0, 1'b1, 32'h200);
        @(negedge clk);
        expect_out("hold_b", 1'b0, 32'h0, 1'b1, 32'h200);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        expect_out("flush", 1'b1, 32'h300, 1'b0, 32'h0);
        redirect_valid = 1'b0; hold_fd = 1'b0;
        @(negedge clk);
        expect_out("wait300", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        expect_out("out300", 1'b1, 32'h308, 1'b1, 32'h300);

        // Address wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        expect_out("drain308", 1'b0, 32'h0, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        @(negedge clk);
        expect_out("req_top", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        @(negedge clk);
        expect_out("wait_top", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        expect_out("wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFF8);
        @(negedge clk);
        expect_out("wait0", 1'b0, 32'h0, 1'b0, 32'h0);

        // Asynchronous reset with a request outstanding.
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b1, 32'h0, 1'b0, 32'h0);
        chk("async_rst pc_addr_f", 64'(pc_addr_f), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_out("rst_rel", 1'b1, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        expect_out("rst_wait", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        expect_out("rst_out", 1'b1, 32'h8, 1'b1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
